dff_response_checker: RTL and testbench

- Receiving end of the registered-vector path: samples the word a flip-flop stage presents on its Q output and compares it against a loaded sequence of expected words.
- Expected vectors are written through a small write port. A run is started, each valid sample is scored in order, and a pass/fail verdict is reported with diagnostic capture of the first mismatch.
- Sits beside a 1..N-bit flip-flop instance as a self-checking monitor, replacing hand-coded final-value checks.

---
 rtl/dff_response_checker.sv | 178 +++++++++++++++++
 tb/tb_dff_response_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
// -----------------------------------------------------------------------------
// dff_response_checker
//
// Self-checking monitor that sits beside a registered-vector (flip-flop) stage.
// A short sequence of expected words is loaded through a write port; a run is
// then started and every valid Q sample is compared, in order, against the
// stored sequence. The run ends after DEPTH samples or after TIMEOUT idle
// cycles. It ends with a pass/fail verdict, match/mismatch counts and a capture
// of the first mismatching sample.
//
// Ports:
//   Clock        rising-edge clock
//   Resetn       synchronous active-low reset
//   exp_wr_en    expected-memory write strobe (ignored while a run is active)
//   exp_wr_addr  expected-memory write index
//   exp_wr_data  expected word
//   start        one-cycle pulse that begins a run (ignored while running)
//   Q_in         observed flip-flop output
//   Q_valid      Q_in holds a sample to be scored this cycle
//   busy         run in progress
//   done         run finished (sticky until the next accepted start)
//   pass         finished with no mismatches and no timeout
//   timeout      run aborted because no sample arrived for TIMEOUT cycles
//   match_cnt    saturating count of matching samples
//   mismatch_cnt saturating count of mismatching samples
//   fail_idx     index of the first mismatch
//   fail_data    Q_in captured at the first mismatch
// -----------------------------------------------------------------------------
module dff_response_checker #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             exp_wr_en,
    input  logic [AW-1:0]    exp_wr_addr,
    input  logic [WIDTH-1:0] exp_wr_data,
    input  logic             start,
    input  logic [WIDTH-1:0] Q_in,
    input  logic             Q_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [AW-1:0]    fail_idx,
    output logic [WIDTH-1:0] fail_data
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  exp_mem [DEPTH];
    logic [AW-1:0]     idx;
    logic [IW-1:0]     idle_cnt;
    logic [IW-1:0]     idle_nxt;
    logic              hit;
    logic              last_sample;
    logic              idle_expired;

    // Counters stick at all-ones rather than wrapping back to zero, so a
    // saturated mismatch count can never masquerade as a clean run.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign hit          = (Q_in == exp_mem[idx]);
    assign last_sample  = (idx == AW'(DEPTH - 1));
    assign idle_nxt     = idle_cnt + IW'(1);
    assign idle_expired = (idle_nxt == IW'(TIMEOUT));
    assign busy         = (state == RUN);

    // Expected memory: not reset, and frozen while a run is in progress.
    always_ff @(posedge Clock) begin
        if (exp_wr_en && (state != RUN)) begin
            exp_mem[exp_wr_addr] <= exp_wr_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (Q_valid) begin
                    if (last_sample) begin
                        state_nxt = DONE;
                    end
                end else if (idle_expired) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
            fail_data    <= '0;
            idx          <= '0;
            idle_cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A start wins over a coincident Q_valid: nothing is scored.
                    if (start) begin
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        timeout      <= 1'b0;
                        match_cnt    <= '0;
                        mismatch_cnt <= '0;
                        fail_idx     <= '0;
                        fail_data    <= '0;
                        idx          <= '0;
                        idle_cnt     <= '0;
                    end
                end
                RUN: begin
                    if (Q_valid) begin
                        if (hit) begin
                            match_cnt <= sat_inc(match_cnt);
                        end else begin
                            mismatch_cnt <= sat_inc(mismatch_cnt);
                            if (mismatch_cnt == '0) begin
                                fail_idx  <= idx;
                                fail_data <= Q_in;
                            end
                        end
                        idx      <= idx + AW'(1);
                        idle_cnt <= '0;
                        if (last_sample) begin
                            done <= 1'b1;
                            // Verdict uses the count including this last sample.
                            pass <= (mismatch_cnt == '0) && hit;
                        end
                    end else begin
                        idle_cnt <= idle_nxt;
                        if (idle_expired) begin
                            done    <= 1'b1;
                            timeout <= 1'b1;
                            pass    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_response_checker.sv
module tb_dff_response_checker;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic             Clock;
    logic             Resetn;
    logic             exp_wr_en;
    logic [AW-1:0]    exp_wr_addr;
    logic [WIDTH-1:0] exp_wr_data;
    logic             start;
    logic [WIDTH-1:0] Q_in;
    logic             Q_valid;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [AW-1:0]    fail_idx;
    logic [WIDTH-1:0] fail_data;

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] golden [DEPTH];

    dff_response_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock(Clock), .Resetn(Resetn),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .start(start), .Q_in(Q_in), .Q_valid(Q_valid),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
        .fail_idx(fail_idx), .fail_data(fail_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic write_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        exp_wr_en = 1'b1; exp_wr_addr = a; exp_wr_data = d;
        tick();
        exp_wr_en = 1'b0;
    endtask

    task automatic load_default();
        for (int i = 0; i < DEPTH; i++) write_exp(AW'(i), golden[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [WIDTH-1:0] w);
        Q_in = w; Q_valid = 1'b1;
        tick();
        Q_valid = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass got %0b want 0", pass); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %0b want 0", timeout); end
        vectors++; if (match_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_match got %0d want 0", match_cnt); end
        vectors++; if (mismatch_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_mismatch got %0d want 0", mismatch_cnt); end
        vectors++; if (fail_data !== 16'h0000) begin miscompares++; $display("FAIL reset_fail_data got %h want 0000", fail_data); end
    endtask

    task automatic test_all_match();
        load_default();
        pulse_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL match_busy got %0b want 1", busy); end
        feed(16'hAAAA); feed(16'h5555); feed(16'hF0F0);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL match_early_done got %0b want 0", done); end
        feed(16'h0F0F);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL match_done got %0b want 1", done); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL match_pass got %0b want 1", pass); end
        vectors++; if (match_cnt !== 8'd4) begin miscompares++; $display("FAIL match_cnt got %0d want 4", match_cnt); end
        vectors++; if (mismatch_cnt !== 8'd0) begin miscompares++; $display("FAIL match_mis got %0d want 0", mismatch_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL match_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_mismatch();
        pulse_start();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mis_done_cleared got %0b want 0", done); end
        feed(16'hAAAA); feed(16'h5554); feed(16'hF0F0); feed(16'h0000);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mis_done got %0b want 1", done); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL mis_pass got %0b want 0", pass); end
        vectors++; if (match_cnt !== 8'd2) begin miscompares++; $display("FAIL mis_match got %0d want 2", match_cnt); end
        vectors++; if (mismatch_cnt !== 8'd2) begin miscompares++; $display("FAIL mis_mis got %0d want 2", mismatch_cnt); end
        vectors++; if (fail_idx !== 2'd1) begin miscompares++; $display("FAIL mis_fail_idx got %0d want 1", fail_idx); end
        vectors++; if (fail_data !== 16'h5554) begin miscompares++; $display("FAIL mis_fail_data got %h want 5554", fail_data); end
    endtask

    task automatic test_timeout();
        pulse_start();
        feed(16'hAAAA); feed(16'h5555);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL to_early_done got %0b want 0", done); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL to_early_busy got %0b want 1", busy); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL to_done got %0b want 1", done); end
        vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_timeout got %0b want 1", timeout); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL to_pass got %0b want 0", pass); end
        vectors++; if (match_cnt !== 8'd2) begin miscompares++; $display("FAIL to_match got %0d want 2", match_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy got %0b want 0", busy); end
    endtask

    task automatic test_run_lockout();
        pulse_start();
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL lock_timeout_cleared got %0b want 0", timeout); end
        feed(16'hAAAA);
        exp_wr_en = 1'b1; exp_wr_addr = 2'd2; exp_wr_data = 16'h1234; start = 1'b1;
        tick();
        exp_wr_en = 1'b0; start = 1'b0;
        vectors++; if (match_cnt !== 8'd1) begin miscompares++; $display("FAIL lock_restart_match got %0d want 1", match_cnt); end
        feed(16'h5555); feed(16'hF0F0); feed(16'h0F0F);
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL lock_pass got %0b want 1", pass); end
        vectors++; if (match_cnt !== 8'd4) begin miscompares++; $display("FAIL lock_match got %0d want 4", match_cnt); end
        pulse_start();
        feed(16'hAAAA); feed(16'h5555); feed(16'h1234); feed(16'h0F0F);
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL rb_pass got %0b want 0", pass); end
        vectors++; if (fail_idx !== 2'd2) begin miscompares++; $display("FAIL rb_fail_idx got %0d want 2", fail_idx); end
        vectors++; if (fail_data !== 16'h1234) begin miscompares++; $display("FAIL rb_fail_data got %h want 1234", fail_data); end
        vectors++; if (mismatch_cnt !== 8'd1) begin miscompares++; $display("FAIL rb_mis got %0d want 1", mismatch_cnt); end
    endtask

    task automatic test_mid_run_reset();
        pulse_start();
        feed(16'hAAAA); feed(16'h5555);
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %0b want 0", done); end
        vectors++; if (match_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_match got %0d want 0", match_cnt); end
        vectors++; if (fail_idx !== 2'd0) begin miscompares++; $display("FAIL rst_fail_idx got %0d want 0", fail_idx); end
        pulse_start();
        for (int i = 0; i < DEPTH; i++) feed(golden[i]);
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL rst_retain_pass got %0b want 1", pass); end
        vectors++; if (match_cnt !== 8'd4) begin miscompares++; $display("FAIL rst_retain_match got %0d want 4", match_cnt); end
    endtask

    task automatic test_restart_after_pass();
        // start coincident with Q_valid: the sample must not be scored
        Q_in = 16'hAAAA; Q_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; Q_valid = 1'b0;
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL re_pass_cleared got %0b want 0", pass); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL re_done_cleared got %0b want 0", done); end
        vectors++; if (match_cnt !== 8'd0) begin miscompares++; $display("FAIL re_start_priority got %0d want 0", match_cnt); end
        feed(16'h1111); feed(16'h2222); feed(16'h3333); feed(16'h4444);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL re_done got %0b want 1", done); end
        vectors++; if (mismatch_cnt !== 8'd4) begin miscompares++; $display("FAIL re_mis got %0d want 4", mismatch_cnt); end
        vectors++; if (match_cnt !== 8'd0) begin miscompares++; $display("FAIL re_match got %0d want 0", match_cnt); end
        vectors++; if (fail_idx !== 2'd0) begin miscompares++; $display("FAIL re_fail_idx got %0d want 0", fail_idx); end
        vectors++; if (fail_data !== 16'h1111) begin miscompares++; $display("FAIL re_fail_data got %h want 1111", fail_data); end
        // Q_valid in DONE is ignored
        feed(16'h0F0F);
        vectors++; if (mismatch_cnt !== 8'd4 || match_cnt !== 8'd0) begin miscompares++; $display("FAIL done_hold got %0d/%0d want 0/4", match_cnt, mismatch_cnt); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        golden[0] = 16'hAAAA; golden[1] = 16'h5555; golden[2] = 16'hF0F0; golden[3] = 16'h0F0F;
        Resetn = 1'b0; exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
        start = 1'b0; Q_in = '0; Q_valid = 1'b0;
        tick(); tick();
        test_reset();
        Resetn = 1'b1;
        tick();
        test_all_match();
        test_mismatch();
        test_timeout();
        test_run_lockout();
        test_mid_run_reset();
        test_restart_after_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
